tdm_demux4: RTL and testbench
=============================

# tdm_demux4

Time-division demultiplexer: the receive-side counterpart of the team's N-to-1 multiplexers. It takes one sample stream carrying N interleaved channels, with a frame-sync strobe marking slot 0. It steers each sample into its channel register and presents complete frames atomically on N parallel outputs. It sits after a TDM link or shared bus, wherever a mux-select sequence must be undone.

## Interface
- `WIDTH`, default 8: bits per sample.
- `N`, default 4: channels per frame; must be ≥ 2.
- `SW`, default $clog2(N): slot counter width; derived, do not override.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock; all state is on its rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `din`, in, WIDTH: incoming sample.
- `din_valid`, in, 1: `din` carries a sample this cycle.
- `fsync`, in, 1: the current valid sample is slot 0. Ignored when `din_valid` is 0.
- `dout`, out, N*WIDTH: frame output. Channel k occupies bits [k*WIDTH +: WIDTH].
- `frame_valid`, out, 1: one-cycle pulse; `dout` has just been updated with a complete frame.
- `slot`, out, SW: slot index the next valid sample will be written to.
- `locked`, out, 1: the block is in state LOCKED.
- `sync_err`, out, 1: one-cycle pulse when `fsync` arrives at an unexpected slot.

## Operation
- State machine: HUNT (reset state) and LOCKED.
- HUNT:
  - A valid sample without `fsync` is discarded.
  - A valid sample with `fsync` is written to working slot 0; `slot` becomes 1 and the state moves to LOCKED.
- LOCKED, valid sample without `fsync`:
  - The sample is written to working slot `slot`, and `slot` increments.
  - At `slot`=N-1: `dout` is loaded with working slots 0..N-2 plus the current `din` in a single edge; `frame_valid` pulses; `slot` wraps to 0.
- LOCKED, valid sample with `fsync`:
  - At `slot`=0 (expected): normal capture into slot 0.
  - At `slot`≠0: `sync_err` pulses and the partial frame is dropped (no `frame_valid`, `dout` unchanged). The sample is written to slot 0, `slot` becomes 1, and the state stays LOCKED.
- Gaps: while `din_valid` is 0, nothing changes and `slot` holds. Gaps of any length are legal mid-frame.
- The working bank is internal only. `dout` changes only on edges where `frame_valid` is asserted, so it is always a coherent frame.
- N=2 is legal: the frame completes on the second sample.

## Timing
- Throughput: one sample per cycle, with no mandatory idle cycles between frames.
- Latency: the last sample of a frame, sampled at edge k, appears on `dout` with `frame_valid`=1 immediately after edge k. `frame_valid` is high for exactly one cycle.
- `sync_err` is asserted the cycle after the offending edge, for one cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset values: `dout`=0, `frame_valid`=0, `sync_err`=0, `slot`=0, `locked`=0. The working bank is cleared and the state is HUNT.
- Reset asserted mid-frame discards the partial frame immediately and asynchronously. After release, the block hunts for the next `fsync`.

## Configuration
- Macro: `TDM_DEMUX_ERRCNT_EN`.
- Defined: the block adds output port `err_count` (8 bits, reset 0). It increments on every `sync_err` pulse and saturates at 255. It clears only on reset.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Basic frame (N=4, WIDTH=8): reset, then send valid samples 0x11, 0x22, 0x33, 0x44 with `fsync` on 0x11. Required: `frame_valid` pulses once, `dout`=0x44332211, `slot`=0.
- Mux inverse: send samples {1,1,0,0} for select 0..3 with WIDTH=1 (the same pattern the 4-to-1 mux bench uses). Required: `dout`=4'b0011, i.e. channels 0 and 1 = 1, channels 2 and 3 = 0.
- Hunt: send 0xAA and 0xBB without `fsync`, then a full frame starting with `fsync`. Required: `locked` stays 0 until `fsync`; 0xAA and 0xBB never appear on `dout`.
- Gaps and back-to-back: insert 3 idle cycles between slots 1 and 2, then start the next frame on the cycle after slot 3. Required: both frames are correct, `frame_valid` pulses exactly 2 times, and `slot` holds during the gap.
- Misaligned sync: after slots 0 and 1, assert `fsync` with 0x55, then send 0x66, 0x77, 0x88. Required: `sync_err` pulses once, no `frame_valid` for the partial frame, then `dout`=0x88776655. With the macro defined, `err_count`=1.
- Reset mid-frame: pull `rst_n` low after slot 2. Required: all outputs are at reset values immediately, `locked`=0, and the next frame decodes correctly.

Source files
------------

// File: rtl/tdm_demux4_if.sv
// Sample-stream and frame-output bundle for tdm_demux4.
// Parameters must match the tdm_demux4 instance that uses this bundle.
// Ports:
//   slave  - the demux side: takes din/din_valid/fsync, drives the frame and status outputs.
//   master - the source side: drives samples and observes frames.
interface tdm_demux4_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SW    = $clog2(N)
);
    logic [WIDTH-1:0]   din;
    logic               din_valid;
    logic               fsync;
    logic [N*WIDTH-1:0] dout;
    logic               frame_valid;
    logic [SW-1:0]      slot;
    logic               locked;
    logic               sync_err;

    modport slave (
        input  din, din_valid, fsync,
        output dout, frame_valid, slot, locked, sync_err
    );

    modport master (
        output din, din_valid, fsync,
        input  dout, frame_valid, slot, locked, sync_err
    );
endinterface

// File: rtl/tdm_demux4.sv
// TDM demultiplexer: steers N interleaved channels into a working bank and publishes whole frames.
// Latency: last sample of a frame sampled at edge k is on dout with frame_valid high right after edge k.
// Backpressure: none; accepts one sample per cycle, din_valid gaps of any length hold all state.
// Ports: clk, rst_n (async active-low), bus (tdm_demux4_if.slave: din/din_valid/fsync in;
//        dout/frame_valid/slot/locked/sync_err out).
// Optional: define TDM_DEMUX_ERRCNT_EN to add err_count, a saturating 8-bit count of sync_err pulses.
module tdm_demux4 #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SW    = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    tdm_demux4_if.slave  bus
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    output logic [7:0]   err_count
`endif
);

    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [SW-1:0]      slot_q, slot_d;
    logic [WIDTH-1:0]   work_q [N];
    logic [N*WIDTH-1:0] dout_q;
    logic [N*WIDTH-1:0] frame_nxt;
    logic               fv_q;
    logic               se_q;

    logic               wr_en;
    logic [SW-1:0]      wr_idx;
    logic               frame_done;
    logic               err;

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        wr_en      = 1'b0;
        wr_idx     = slot_q;
        frame_done = 1'b0;
        err        = 1'b0;
        if (bus.din_valid) begin
            case (state_q)
                HUNT: begin
                    if (bus.fsync) begin
                        wr_en   = 1'b1;
                        wr_idx  = '0;
                        slot_d  = SW'(1);
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    wr_en = 1'b1;
                    if (bus.fsync && (slot_q != '0)) begin
                        // Resync: abandon the partial frame, this sample restarts slot 0.
                        err    = 1'b1;
                        wr_idx = '0;
                        slot_d = SW'(1);
                    end else if (slot_q == SW'(N - 1)) begin
                        frame_done = 1'b1;
                        slot_d     = '0;
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Completed frame: stored slots 0..N-2 plus the sample arriving now as slot N-1.
    always_comb begin
        frame_nxt = '0;
        for (int k = 0; k < N; k++) begin
            frame_nxt[k*WIDTH +: WIDTH] = (k == N - 1) ? bus.din : work_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            slot_q  <= '0;
            dout_q  <= '0;
            fv_q    <= 1'b0;
            se_q    <= 1'b0;
            for (int k = 0; k < N; k++) begin
                work_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            fv_q    <= frame_done;
            se_q    <= err;
            if (frame_done) begin
                dout_q <= frame_nxt;
            end
            if (wr_en) begin
                work_q[wr_idx] <= bus.din;
            end
        end
    end

`ifdef TDM_DEMUX_ERRCNT_EN
    // Updated on the same edge that raises sync_err so both are visible together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

    assign bus.dout        = dout_q;
    assign bus.frame_valid = fv_q;
    assign bus.slot        = slot_q;
    assign bus.locked      = (state_q == LOCKED);
    assign bus.sync_err    = se_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: main 8-bit/4-channel instance, a 1-bit instance, and an N=2 instance.
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
// Ends with a single summary line of checks and errors.
module tb_tdm_demux4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tdm_demux4_if #(.WIDTH(8), .N(4)) b8 ();
    tdm_demux4_if #(.WIDTH(1), .N(4)) b1 ();
    tdm_demux4_if #(.WIDTH(8), .N(2)) b2 ();

`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0] ec8, ec1, ec2;
`endif

    tdm_demux4 #(.WIDTH(8), .N(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .bus(b8)
`ifdef TDM_DEMUX_ERRCNT_EN
        , .err_count(ec8)
`endif
    );

    tdm_demux4 #(.WIDTH(1), .N(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1)
`ifdef TDM_DEMUX_ERRCNT_EN
        , .err_count(ec1)
`endif
    );

    tdm_demux4 #(.WIDTH(8), .N(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(b2)
`ifdef TDM_DEMUX_ERRCNT_EN
        , .err_count(ec2)
`endif
    );

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One sample slot on the main instance; returns with post-edge outputs visible.
    task automatic step(input logic v, input logic [7:0] d, input logic fs);
        @(negedge clk);
        b8.din_valid = v;
        b8.din       = d;
        b8.fsync     = fs;
        @(posedge clk);
        #1;
        fv_cnt += int'(b8.frame_valid);
    endtask

    task automatic step1(input logic d, input logic fs);
        @(negedge clk);
        b1.din_valid = 1'b1;
        b1.din       = d;
        b1.fsync     = fs;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic [7:0] d, input logic fs);
        @(negedge clk);
        b2.din_valid = 1'b1;
        b2.din       = d;
        b2.fsync     = fs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        b8.din = '0; b8.din_valid = 1'b0; b8.fsync = 1'b0;
        b1.din = '0; b1.din_valid = 1'b0; b1.fsync = 1'b0;
        b2.din = '0; b2.din_valid = 1'b0; b2.fsync = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", 64'(b8.dout), 64'h0);
        check("rst_fv", 64'(b8.frame_valid), 64'h0);
        check("rst_se", 64'(b8.sync_err), 64'h0);
        check("rst_slot", 64'(b8.slot), 64'h0);
        check("rst_locked", 64'(b8.locked), 64'h0);
`ifdef TDM_DEMUX_ERRCNT_EN
        check("rst_errcnt", 64'(ec8), 64'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Hunt: samples before fsync are dropped.
        step(1'b1, 8'hAA, 1'b0);
        check("hunt_locked_a", 64'(b8.locked), 64'h0);
        check("hunt_slot_a", 64'(b8.slot), 64'h0);
        step(1'b1, 8'hBB, 1'b0);
        check("hunt_locked_b", 64'(b8.locked), 64'h0);

        // Basic frame.
        fv_cnt = 0;
        step(1'b1, 8'h11, 1'b1);
        check("basic_locked", 64'(b8.locked), 64'h1);
        check("basic_slot1", 64'(b8.slot), 64'h1);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        check("basic_slot3", 64'(b8.slot), 64'h3);
        check("basic_dout_held", 64'(b8.dout), 64'h0);
        step(1'b1, 8'h44, 1'b0);
        check("basic_fv", 64'(b8.frame_valid), 64'h1);
        check("basic_dout", 64'(b8.dout), 64'h44332211);
        check("basic_slot0", 64'(b8.slot), 64'h0);
        step(1'b0, 8'h00, 1'b0);
        check("basic_fv_pulse", 64'(b8.frame_valid), 64'h0);
        check("basic_fv_count", 64'(fv_cnt), 64'd1);

        // Mux inverse, WIDTH=1.
        step1(1'b1, 1'b1);
        step1(1'b1, 1'b0);
        step1(1'b0, 1'b0);
        step1(1'b0, 1'b0);
        check("mux_inv_fv", 64'(b1.frame_valid), 64'h1);
        check("mux_inv_dout", 64'(b1.dout), 64'h3);
        @(negedge clk);
        b1.din_valid = 1'b0;

        // N=2: frame completes on the second sample.
        step2(8'hA1, 1'b1);
        check("n2_slot", 64'(b2.slot), 64'h1);
        check("n2_fv_early", 64'(b2.frame_valid), 64'h0);
        step2(8'hB2, 1'b0);
        check("n2_fv", 64'(b2.frame_valid), 64'h1);
        check("n2_dout", 64'(b2.dout), 64'hB2A1);
        check("n2_slot_wrap", 64'(b2.slot), 64'h0);
        @(negedge clk);
        b2.din_valid = 1'b0;

        // Gaps and back-to-back frames.
        fv_cnt = 0;
        step(1'b1, 8'h01, 1'b1);
        step(1'b1, 8'h02, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'hEE, 1'b1);
            check("gap_slot", 64'(b8.slot), 64'h2);
        end
        step(1'b1, 8'h03, 1'b0);
        step(1'b1, 8'h04, 1'b0);
        check("gap_dout1", 64'(b8.dout), 64'h04030201);
        step(1'b1, 8'h05, 1'b1);
        check("b2b_fv_low", 64'(b8.frame_valid), 64'h0);
        step(1'b1, 8'h06, 1'b0);
        step(1'b1, 8'h07, 1'b0);
        step(1'b1, 8'h08, 1'b0);
        check("b2b_dout2", 64'(b8.dout), 64'h08070605);
        step(1'b0, 8'h00, 1'b0);
        check("gap_fv_count", 64'(fv_cnt), 64'd2);

        // Misaligned fsync.
        fv_cnt = 0;
        step(1'b1, 8'hA0, 1'b1);
        step(1'b1, 8'hA1, 1'b0);
        check("mis_slot2", 64'(b8.slot), 64'h2);
        step(1'b1, 8'h55, 1'b1);
        check("mis_se", 64'(b8.sync_err), 64'h1);
        check("mis_slot1", 64'(b8.slot), 64'h1);
        check("mis_dout_held", 64'(b8.dout), 64'h08070605);
`ifdef TDM_DEMUX_ERRCNT_EN
        check("mis_errcnt", 64'(ec8), 64'h1);
`endif
        step(1'b1, 8'h66, 1'b0);
        check("mis_se_pulse", 64'(b8.sync_err), 64'h0);
        step(1'b1, 8'h77, 1'b0);
        step(1'b1, 8'h88, 1'b0);
        check("mis_dout", 64'(b8.dout), 64'h88776655);
        check("mis_fv_count", 64'(fv_cnt), 64'd1);

        // Reset mid-frame.
        step(1'b1, 8'hC0, 1'b1);
        step(1'b1, 8'hC1, 1'b0);
        step(1'b1, 8'hC2, 1'b0);
        @(negedge clk);
        b8.din_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mrst_dout", 64'(b8.dout), 64'h0);
        check("mrst_slot", 64'(b8.slot), 64'h0);
        check("mrst_locked", 64'(b8.locked), 64'h0);
        check("mrst_fv", 64'(b8.frame_valid), 64'h0);
        check("mrst_se", 64'(b8.sync_err), 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'hD0, 1'b0);
        check("mrst_hunt", 64'(b8.locked), 64'h0);
        step(1'b1, 8'hE0, 1'b1);
        step(1'b1, 8'hE1, 1'b0);
        step(1'b1, 8'hE2, 1'b0);
        step(1'b1, 8'hE3, 1'b0);
        check("mrst_fv_after", 64'(b8.frame_valid), 64'h1);
        check("mrst_dout_after", 64'(b8.dout), 64'hE3E2E1E0);
        step(1'b0, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
